// File: rtl/itl_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : itl_frame_sched
// Brief    : Round-robin frame scheduler and write/read sequencer for the
//            interleaver RAM; one frame in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module itl_frame_sched #(
  parameter int LEN_W   = 13,
  parameter int MAX_LEN = 5120,
  parameter int ID_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [2*LEN_W-1:0]  req_len,
  input  logic [2*ID_W-1:0]   req_id,
  input  logic [3:0]          req_mode,
  output logic [1:0]          gnt,
  input  logic                s_din_vld,
  output logic                wen,
  output logic [LEN_W-1:0]    waddr,
  output logic [LEN_W-1:0]    raddr,
  output logic                rd_en,
  output logic [1:0]          rd_mode,
  output logic [ID_W-1:0]     link_id,
  input  logic                rd_ready,
  output logic                dout_vld,
  output logic                dout_last,
  output logic                done,
  output logic                err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] TURN  = 3'd3;
  localparam logic [2:0] READ  = 3'd4;
  localparam logic [2:0] FLUSH = 3'd5;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             ptr;
  logic             win;
  logic [1:0]       gnt_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] len_last;
  logic [ID_W-1:0]  id_r;
  logic [1:0]       mode_r;
  logic [LEN_W-1:0] wcnt;
  logic [LEN_W-1:0] rcnt;
  logic             dv_r;
  logic             dl_r;
  logic             bad;
  logic             w_last;
  logic             r_last;

  logic [LEN_W-1:0] src_len  [2];
  logic [ID_W-1:0]  src_id   [2];
  logic [1:0]       src_mode [2];

  for (genvar i = 0; i < 2; i++) begin : g_src
    assign src_len[i]  = req_len[i*LEN_W +: LEN_W];
    assign src_id[i]   = req_id[i*ID_W +: ID_W];
    assign src_mode[i] = req_mode[i*2 +: 2];
  end

  // ptr names the preferred source when both request at once
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ptr;
    end else if (req[1]) begin
      win = 1'b1;
    end
  end

  assign len_last = len_r - ONE_C;
  assign bad      = (len_r == '0) || (len_r > MAX_LEN_C) || (mode_r == 2'd3);
  assign w_last   = (wcnt == len_last);
  assign r_last   = (rcnt == len_last);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = CHECK;
      CHECK:   state_nxt = bad ? IDLE : LOAD;
      LOAD:    if (s_din_vld && w_last) state_nxt = TURN;
      TURN:    state_nxt = READ;
      READ:    if (rd_ready && r_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wen   = 1'b0;
    rd_en = 1'b0;
    err   = 1'b0;
    done  = 1'b0;
    case (state)
      CHECK:   err   = bad;
      LOAD:    wen   = s_din_vld;
      READ:    rd_en = rd_ready;
      FLUSH:   done  = 1'b1;
      default: ;
    endcase
  end

  // Frame context, counters and registered read-side strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      gnt_r  <= '0;
      len_r  <= '0;
      id_r   <= '0;
      mode_r <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
      dv_r   <= 1'b0;
      dl_r   <= 1'b0;
    end else begin
      dv_r <= rd_en;
      dl_r <= rd_en && r_last;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_r  <= win ? 2'b10 : 2'b01;
            len_r  <= src_len[win];
            id_r   <= src_id[win];
            mode_r <= src_mode[win];
            wcnt   <= '0;
          end
        end
        CHECK: begin
          if (bad) begin
            gnt_r <= '0;
            ptr   <= ~gnt_r[1];
          end
        end
        LOAD: begin
          if (s_din_vld) wcnt <= wcnt + ONE_C;
        end
        TURN: begin
          rcnt <= '0;
        end
        READ: begin
          if (rd_ready) rcnt <= rcnt + ONE_C;
        end
        FLUSH: begin
          gnt_r <= '0;
          ptr   <= ~gnt_r[1];
        end
        default: ;
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign waddr     = wcnt;
  assign raddr     = rcnt;
  assign rd_mode   = mode_r;
  assign link_id   = id_r;
  assign dout_vld  = dv_r;
  assign dout_last = dl_r;

endmodule
`default_nettype wire

// File: tb/tb_itl_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_itl_frame_sched
// Brief    : Directed self-checking bench for itl_frame_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_itl_frame_sched;

  localparam int LEN_W = 13;
  localparam int ID_W  = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         req = '0;
  logic [2*LEN_W-1:0] req_len = '0;
  logic [2*ID_W-1:0]  req_id = '0;
  logic [3:0]         req_mode = '0;
  logic [1:0]         gnt;
  logic               s_din_vld = 1'b0;
  logic               wen;
  logic [LEN_W-1:0]   waddr;
  logic [LEN_W-1:0]   raddr;
  logic               rd_en;
  logic [1:0]         rd_mode;
  logic [ID_W-1:0]    link_id;
  logic               rd_ready = 1'b0;
  logic               dout_vld;
  logic               dout_last;
  logic               done;
  logic               err;

  itl_frame_sched #(.LEN_W(LEN_W), .MAX_LEN(5120), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_id(req_id),
    .req_mode(req_mode), .gnt(gnt), .s_din_vld(s_din_vld), .wen(wen),
    .waddr(waddr), .raddr(raddr), .rd_en(rd_en), .rd_mode(rd_mode),
    .link_id(link_id), .rd_ready(rd_ready), .dout_vld(dout_vld),
    .dout_last(dout_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bus monitor: counts strobes and tracks the expected address sequences
  int wen_cnt = 0, rd_cnt = 0, dv_cnt = 0, last_cnt = 0, last_at = 0;
  int done_cnt = 0, err_cnt = 0, hold_bad = 0, gnt_hi = 0, done_bad = 0;
  int exp_waddr = 0, exp_raddr = 0, last_waddr = -1;
  logic [1:0]      prev_gnt = '0;
  logic [1:0]      exp_mode = '0;
  logic [ID_W-1:0] exp_id = '0;
  logic [1:0]      gnt_log[$];

  always @(negedge clk) begin
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      gnt_log.push_back(gnt);
      exp_waddr = 0;
      exp_raddr = 0;
      exp_mode  = gnt[1] ? req_mode[3:2] : req_mode[1:0];
      exp_id    = gnt[1] ? req_id[2*ID_W-1:ID_W] : req_id[ID_W-1:0];
    end
    if (gnt != 2'b00) begin
      gnt_hi++;
      if (rd_mode !== exp_mode || link_id !== exp_id) hold_bad++;
    end
    if (wen) begin
      check_val("waddr_seq", 32'(waddr), 32'(exp_waddr));
      exp_waddr++;
      wen_cnt++;
      last_waddr = int'(waddr);
    end
    if (rd_en) begin
      check_val("raddr_seq", 32'(raddr), 32'(exp_raddr));
      exp_raddr++;
      rd_cnt++;
    end
    if (dout_vld) dv_cnt++;
    if (dout_last) begin
      last_cnt++;
      last_at = dv_cnt;
    end
    if (done) begin
      done_cnt++;
      if (!(dout_vld && dout_last)) done_bad++;
    end
    if (err) err_cnt++;
    prev_gnt = gnt;
  end

  task automatic clear_mon();
    wen_cnt = 0; rd_cnt = 0; dv_cnt = 0; last_cnt = 0; last_at = 0;
    done_cnt = 0; err_cnt = 0; hold_bad = 0; gnt_hi = 0; done_bad = 0;
    last_waddr = -1;
    gnt_log.delete();
  endtask

  function automatic logic [1:0] glog(input int i);
    return (gnt_log.size() > i) ? gnt_log[i] : 2'b00;
  endfunction

  int pat_k = 0;

  // vmode 0: continuous; 1: rd_ready pattern 1,0,0,1; 2: random write gaps
  task automatic next_cycle(input int vmode);
    @(posedge clk); #1;
    case (vmode)
      1: begin
        s_din_vld = 1'b1;
        rd_ready  = (pat_k % 4 == 0) || (pat_k % 4 == 3);
        pat_k++;
      end
      2: begin
        s_din_vld = ($urandom_range(0, 2) != 0);
        rd_ready  = 1'b1;
      end
      default: begin
        s_din_vld = 1'b1;
        rd_ready  = 1'b1;
      end
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, input int vmode);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      next_cycle(vmode);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd1);
    @(posedge clk); #1;
    s_din_vld = 1'b0;
    rd_ready  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int lens  [3] = '{0, 5121, 10};
  int modes [3] = '{1, 1, 3};

  initial begin
    int idle;
    int ndone;
    logic started;

    // Reset state, with s_din_vld high to show it is ignored outside LOAD
    rst = 1'b1;
    s_din_vld = 1'b1;
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_strobes", 32'({wen, rd_en, dout_vld, dout_last, done, err}), 32'd0);
    check_val("rst_addr", 32'({waddr, raddr}), 32'd0);
    check_val("rst_ctx", 32'({rd_mode, link_id}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_din_vld = 1'b0;
    rd_ready = 1'b0;

    // Basic frame: source 0, len 40, interleaved mode
    clear_mon();
    req_len = {13'd0, 13'd40};
    req_mode = {2'd0, 2'd1};
    req_id = {6'd0, 6'd5};
    s_din_vld = 1'b1;
    rd_ready = 1'b1;
    req = 2'b01;
    wait_grant("t1_grant", 10);
    check_val("t1_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    wait_done("t1_done", 200, 0);
    check_val("t1_wen_cnt", 32'(wen_cnt), 32'd40);
    check_val("t1_last_waddr", 32'(last_waddr), 32'd39);
    check_val("t1_rd_cnt", 32'(rd_cnt), 32'd40);
    check_val("t1_dv_cnt", 32'(dv_cnt), 32'd40);
    check_val("t1_last_cnt", 32'(last_cnt), 32'd1);
    check_val("t1_last_at", 32'(last_at), 32'd40);
    check_val("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_val("t1_done_last", 32'(done_bad), 32'd0);
    check_val("t1_hold", 32'(hold_bad), 32'd0);
    check_val("t1_gnt_cycles", 32'(gnt_hi), 32'd83);
    check_val("t1_gnt_after", 32'(gnt), 32'd0);
    check_val("t1_mode_kept", 32'({rd_mode, link_id}), 32'({2'd1, 6'd5}));

    // Round robin with both sources requesting continuously
    do_reset();
    clear_mon();
    req_len = {13'd6, 13'd4};
    req_mode = {2'd2, 2'd0};
    req_id = {6'd9, 6'd3};
    s_din_vld = 1'b1;
    rd_ready = 1'b1;
    req = 2'b11;
    idle = 0;
    ndone = 0;
    started = 1'b0;
    for (int i = 0; i < 300 && ndone < 3; i++) begin
      next_cycle(0);
      @(negedge clk);
      if (gnt != 2'b00) started = 1'b1;
      else if (started) idle++;
      if (done) ndone++;
    end
    req = 2'b00;
    check_val("t2_frames", 32'(ndone), 32'd3);
    repeat (3) next_cycle(0);
    @(negedge clk);
    check_val("t2_grants", 32'(gnt_log.size()), 32'd3);
    check_val("t2_order", 32'({glog(0), glog(1), glog(2)}), 32'({2'b01, 2'b10, 2'b01}));
    check_val("t2_idle_gap", 32'(idle), 32'd2);
    check_val("t2_wen_cnt", 32'(wen_cnt), 32'd14);
    check_val("t2_dv_cnt", 32'(dv_cnt), 32'd14);
    check_val("t2_last_cnt", 32'(last_cnt), 32'd3);
    check_val("t2_hold", 32'(hold_bad), 32'd0);
    s_din_vld = 1'b0;
    rd_ready = 1'b0;

    // Rejected requests: zero length, over-length, illegal mode
    do_reset();
    clear_mon();
    s_din_vld = 1'b1;
    rd_ready = 1'b1;
    req_len = {13'd6, 13'd0};
    req_mode = {2'd1, 2'd1};
    req_id = {6'd7, 6'd2};
    for (int k = 0; k < 3; k++) begin
      req_len[LEN_W-1:0] = LEN_W'(lens[k]);
      req_mode[1:0] = 2'(modes[k]);
      req = 2'b01;
      wait_grant("t3_grant", 10);
      check_val("t3_err_pulse", 32'({gnt, err}), 32'({2'b01, 1'b1}));
      req = 2'b00;
      @(negedge clk);
      check_val("t3_err_clear", 32'({gnt, err}), 32'd0);
    end
    check_val("t3_err_cnt", 32'(err_cnt), 32'd3);
    check_val("t3_no_access", 32'(wen_cnt + rd_cnt + done_cnt), 32'd0);
    req_len[LEN_W-1:0] = 13'd10;
    req_mode[1:0] = 2'd1;
    req = 2'b11;
    wait_grant("t3_grant_src1", 10);
    check_val("t3_rr_src1", 32'(gnt), 32'd2);
    req = 2'b00;
    wait_done("t3_done", 100, 0);
    check_val("t3_wen_cnt", 32'(wen_cnt), 32'd6);
    check_val("t3_done_cnt", 32'(done_cnt), 32'd1);
    check_val("t3_ctx", 32'({rd_mode, link_id}), 32'({2'd1, 6'd7}));

    // Backpressure during READ, len 8
    do_reset();
    clear_mon();
    req_len = {13'd0, 13'd8};
    req_mode = {2'd0, 2'd0};
    req_id = {6'd0, 6'd1};
    s_din_vld = 1'b1;
    rd_ready = 1'b1;
    req = 2'b01;
    wait_grant("t4_grant", 10);
    req = 2'b00;
    pat_k = 0;
    wait_done("t4_done", 200, 1);
    check_val("t4_rd_cnt", 32'(rd_cnt), 32'd8);
    check_val("t4_dv_cnt", 32'(dv_cnt), 32'd8);
    check_val("t4_last_at", 32'(last_at), 32'd8);
    check_val("t4_last_cnt", 32'(last_cnt), 32'd1);
    check_val("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Maximum length with random write gaps
    do_reset();
    clear_mon();
    req_len = {13'd0, 13'd5120};
    req_mode = {2'd0, 2'd2};
    req_id = {6'd0, 6'd63};
    s_din_vld = 1'b0;
    rd_ready = 1'b1;
    req = 2'b01;
    wait_grant("t5_grant", 10);
    req = 2'b00;
    wait_done("t5_done", 40000, 2);
    check_val("t5_wen_cnt", 32'(wen_cnt), 32'd5120);
    check_val("t5_last_waddr", 32'(last_waddr), 32'd5119);
    check_val("t5_rd_cnt", 32'(rd_cnt), 32'd5120);
    check_val("t5_last_at", 32'(last_at), 32'd5120);
    check_val("t5_hold", 32'(hold_bad), 32'd0);

    // Reset in the middle of LOAD
    do_reset();
    clear_mon();
    req_len = {13'd6, 13'd40};
    req_mode = {2'd2, 2'd1};
    req_id = {6'd4, 6'd5};
    s_din_vld = 1'b1;
    rd_ready = 1'b1;
    req = 2'b01;
    wait_grant("t6_grant", 10);
    req = 2'b00;
    started = 1'b0;
    for (int i = 0; i < 100 && !started; i++) begin
      next_cycle(0);
      @(negedge clk);
      if (wen && waddr == 13'd17) started = 1'b1;
    end
    check_val("t6_reach17", 32'(started), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_abort", 32'({gnt, wen, rd_en, done}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("t6_no_done", 32'(done_cnt), 32'd0);
    clear_mon();
    req = 2'b10;
    wait_grant("t6_regrant", 10);
    check_val("t6_gnt_src1", 32'(gnt), 32'd2);
    req = 2'b00;
    wait_done("t6_done", 100, 0);
    check_val("t6_wen_cnt", 32'(wen_cnt), 32'd6);
    check_val("t6_dv_cnt", 32'(dv_cnt), 32'd6);
    check_val("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
